cpu: RTL and testbench



---
 rtl/cpu.sv | 97 +++++++++
 tb/tb_cpu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: single-cycle 32-bit core with a 19-bit instruction word.
//   CLK          in   system clock, all state commits on the rising edge
//   RESET        in   asynchronous active-high reset (PC and R0..R15 cleared)
//   PC      [31:0] out  word index of the instruction being executed
//   INSTRUCTION [18:0] in  instruction at PC from a combinational memory
// Decode, register reads and the ALU are combinational; write-back and the
// PC update land together on each rising edge, so the next instruction sees
// the result and a same-cycle read of the destination returns the old value.
module cpu #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          NREGS    = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [18:0] INSTRUCTION
);

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_LOADI = 4'h8;
  localparam logic [3:0] OP_MOV   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_BNE   = 4'hD;
  localparam logic [3:0] OP_SLT   = 4'hE;

  logic [31:0] r_pc;
  logic [31:0] r_regs [NREGS];

  logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm11, w_imm7, w_off15;
  logic [31:0] w_a, w_b, w_d;
  logic [31:0] w_pc_inc;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_next_pc;

  assign w_op    = INSTRUCTION[18:15];
  assign w_rd    = INSTRUCTION[14:11];
  assign w_rs1   = INSTRUCTION[10:7];
  assign w_rs2   = INSTRUCTION[6:3];
  assign w_imm11 = {{21{INSTRUCTION[10]}}, INSTRUCTION[10:0]};
  assign w_imm7  = {{25{INSTRUCTION[6]}},  INSTRUCTION[6:0]};
  assign w_off15 = {{17{INSTRUCTION[14]}}, INSTRUCTION[14:0]};

  // Branches compare the rd field as a source, so three read ports.
  assign w_a = r_regs[w_rs1];
  assign w_b = r_regs[w_rs2];
  assign w_d = r_regs[w_rd];

  assign w_pc_inc = r_pc + 32'd1;
  assign PC       = r_pc;

  always_comb begin
    w_we      = 1'b0;
    w_wdata   = '0;
    w_next_pc = w_pc_inc;
    case (w_op)
      OP_ADD:   begin w_we = 1'b1; w_wdata = w_a + w_b;         end
      OP_SUB:   begin w_we = 1'b1; w_wdata = w_a - w_b;         end
      OP_AND:   begin w_we = 1'b1; w_wdata = w_a & w_b;         end
      OP_OR:    begin w_we = 1'b1; w_wdata = w_a | w_b;         end
      OP_XOR:   begin w_we = 1'b1; w_wdata = w_a ^ w_b;         end
      OP_SLL:   begin w_we = 1'b1; w_wdata = w_a << w_b[4:0];   end
      OP_SRL:   begin w_we = 1'b1; w_wdata = w_a >> w_b[4:0];   end
      OP_LOADI: begin w_we = 1'b1; w_wdata = w_imm11;           end
      OP_MOV:   begin w_we = 1'b1; w_wdata = w_a;               end
      OP_ADDI:  begin w_we = 1'b1; w_wdata = w_a + w_imm7;      end
      OP_SLT:   begin
        w_we    = 1'b1;
        w_wdata = {31'd0, $signed(w_a) < $signed(w_b)};
      end
      OP_BEQ:   if (w_d == w_a) w_next_pc = w_pc_inc + w_imm7;
      OP_BNE:   if (w_d != w_a) w_next_pc = w_pc_inc + w_imm7;
      OP_JMP:   w_next_pc = w_pc_inc + w_off15;
      default:  ; // 0000 and 1111 are NOPs
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_we) r_regs[w_rd] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [18:0] INSTRUCTION;

  logic [18:0] imem [64];
  assign INSTRUCTION = imem[PC[5:0]];

  cpu #(.RESET_PC(32'd0), .NREGS(16)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION)
  );

  initial CLK = 1'b0;
  always #4 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- instruction encoders ----------------
  function automatic logic [18:0] rr(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    logic [3:0] a, b, c;
    a = rd[3:0]; b = rs1[3:0]; c = rs2[3:0];
    return {op, a, b, c, 3'b000};
  endfunction
  function automatic logic [18:0] li(input int rd, input int imm);
    logic [3:0] a;
    a = rd[3:0];
    return {4'h8, a, imm[10:0]};
  endfunction
  function automatic logic [18:0] ri(input logic [3:0] op, input int rd, input int rs1, input int imm);
    logic [3:0] a, b;
    a = rd[3:0]; b = rs1[3:0];
    return {op, a, b, imm[6:0]};
  endfunction
  function automatic logic [18:0] jmp(input int off);
    return {4'hC, off[14:0]};
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_r [16];

  function automatic int sx(input int v, input int bits);
    int half;
    half = 1 << (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Architectural effect of one instruction given the current model state.
  function automatic void exec(input logic [18:0] ins, input logic [31:0] pc,
                               output logic [31:0] npc, output bit we,
                               output int rd, output logic [31:0] val);
    int op, rs1, rs2, d;
    logic [31:0] a, b;
    op  = int'(ins[18:15]);
    rd  = int'(ins[14:11]);
    rs1 = int'(ins[10:7]);
    rs2 = int'(ins[6:3]);
    a   = m_r[rs1];
    b   = m_r[rs2];
    d   = int'(m_r[rd]);
    npc = pc + 1;
    we  = 1'b1;
    val = 32'd0;
    case (op)
      1:  val = a + b;
      2:  val = a - b;
      3:  val = a & b;
      4:  val = a | b;
      5:  val = a ^ b;
      6:  val = a << (b % 32);
      7:  val = a >> (b % 32);
      8:  val = 32'(sx(int'(ins[10:0]), 11));
      9:  val = a;
      10: val = a + 32'(sx(int'(ins[6:0]), 7));
      14: val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      11: begin we = 1'b0; if (d == int'(a)) npc = pc + 1 + 32'(sx(int'(ins[6:0]), 7)); end
      13: begin we = 1'b0; if (d != int'(a)) npc = pc + 1 + 32'(sx(int'(ins[6:0]), 7)); end
      12: begin we = 1'b0; npc = pc + 1 + 32'(sx(int'(ins[14:0]), 15)); end
      default: we = 1'b0;
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin : mdl
    logic [31:0] npc, val;
    bit we;
    int rd;
    if (RESET) begin
      m_pc <= 32'd0;
      for (int i = 0; i < 16; i++) m_r[i] <= 32'd0;
    end else begin
      exec(imem[m_pc[5:0]], m_pc, npc, we, rd, val);
      m_pc <= npc;
      if (we) m_r[rd] <= val;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    n_chk++;
    if (PC !== m_pc) begin
      n_fail++;
      $display("FAIL model_pc t=%0t got=%h exp=%h", $time, PC, m_pc);
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (dut.r_regs[i] !== m_r[i]) begin
        n_fail++;
        $display("FAIL model_r%0d t=%0t got=%h exp=%h", i, $time, dut.r_regs[i], m_r[i]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pc"}, PC, 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", name, i), dut.r_regs[i], 32'd0);
  endtask

  // Sample 2 ns after the n-th following rising edge.
  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 19'd0;
  endtask

  // Caller holds RESET high while loading; release on a falling edge.
  task automatic release_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    // ---- program A: reset, ALU ops, shifts, logic, self-loop, reset pulse ----
    RESET = 1'b1;
    clear_mem();
    imem[0]  = li(0, 'h441);          // bit 10 set -> sign-extends
    imem[1]  = li(1, 5);
    imem[2]  = li(2, -3);
    imem[3]  = rr(4'h1, 3, 1, 2);     // ADD
    imem[4]  = rr(4'h2, 4, 1, 2);     // SUB
    imem[5]  = rr(4'hE, 5, 2, 1);     // SLT
    imem[6]  = li(3, 'h21);
    imem[7]  = li(6, 31);
    imem[8]  = li(1, -1);
    imem[9]  = rr(4'h6, 2, 1, 3);     // SLL by 0x21 -> by 1
    imem[10] = rr(4'h7, 4, 1, 6);     // SRL by 31
    imem[11] = rr(4'h3, 7, 1, 5);     // AND
    imem[12] = rr(4'h4, 8, 3, 6);     // OR
    imem[13] = rr(4'h5, 9, 1, 3);     // XOR
    imem[14] = rr(4'h9, 10, 9, 0);    // MOV
    imem[15] = {4'h0, 15'h7ABC};      // NOP with junk fields
    imem[16] = {4'hF, 15'h1234};      // NOP
    imem[17] = jmp(-1);               // self-loop
    #1 chk_all_zero("reset_t1");
    #4 chk("reset_after_edge_pc", PC, 32'd0);
    #1 RESET = 1'b0;                  // t = 6
    run(1);
    chk("a_pc1", PC, 32'd1);
    chk("a_r0_loadi", dut.r_regs[0], 32'hFFFFFC41);
    run(5);
    chk("a_pc6", PC, 32'd6);
    chk("a_add", dut.r_regs[3], 32'd2);
    chk("a_sub", dut.r_regs[4], 32'd8);
    chk("a_slt", dut.r_regs[5], 32'd1);
    run(5);
    chk("a_pc11", PC, 32'd11);
    chk("a_sll", dut.r_regs[2], 32'hFFFFFFFE);
    chk("a_srl", dut.r_regs[4], 32'd1);
    run(6);
    chk("a_pc17", PC, 32'd17);
    chk("a_and", dut.r_regs[7], 32'd1);
    chk("a_or",  dut.r_regs[8], 32'h3F);
    chk("a_xor", dut.r_regs[9], 32'hFFFFFFDE);
    chk("a_mov", dut.r_regs[10], 32'hFFFFFFDE);
    run(3);
    chk("a_selfloop", PC, 32'd17);
    // Mid-cycle reset pulse: edge+3 .. edge+5, clear visible at once.
    #1 RESET = 1'b1;
    #1 chk_all_zero("pulse");
    #1 RESET = 1'b0;
    run(1);
    chk("a_restart_pc", PC, 32'd1);
    chk("a_restart_r0", dut.r_regs[0], 32'hFFFFFC41);
    chk("a_restart_r5", dut.r_regs[5], 32'd0);

    // ---- program B: BEQ taken ----
    RESET = 1'b1;
    clear_mem();
    imem[0] = li(1, 1);
    imem[1] = ri(4'hA, 1, 1, -1);     // ADDI
    imem[2] = ri(4'hB, 1, 0, 2);      // BEQ R1,R0,+2
    imem[3] = li(12, 7);              // skipped
    imem[4] = li(12, 7);              // skipped
    imem[5] = ri(4'hD, 1, 0, 2);      // BNE not taken
    imem[6] = jmp(-1);
    release_reset();
    run(2);
    chk("b_pc2", PC, 32'd2);
    chk("b_addi", dut.r_regs[1], 32'd0);
    run(1);
    chk("b_beq_taken", PC, 32'd5);
    run(1);
    chk("b_bne_not_taken", PC, 32'd6);
    run(2);
    chk("b_skipped_r12", dut.r_regs[12], 32'd0);

    // ---- program C: BNE not taken, JMP forward, BEQ self-loop ----
    RESET = 1'b1;
    clear_mem();
    imem[0]  = li(1, 1);
    imem[1]  = ri(4'hA, 1, 1, -1);
    imem[2]  = ri(4'hD, 1, 0, 2);     // BNE not taken
    imem[3]  = 19'd0;
    imem[4]  = jmp(10);
    imem[15] = ri(4'hB, 1, 0, -1);    // BEQ taken, offset -1
    release_reset();
    run(3);
    chk("c_bne_pc3", PC, 32'd3);
    run(2);
    chk("c_jmp_pc15", PC, 32'd15);
    run(3);
    chk("c_beq_selfloop", PC, 32'd15);

    // ---- program D: wrap-around arithmetic, immediate limits, PC wrap ----
    RESET = 1'b1;
    clear_mem();
    imem[0]  = li(1, -1);
    imem[1]  = ri(4'hA, 2, 1, 1);     // -1 + 1 wraps to 0
    imem[2]  = rr(4'h1, 3, 1, 1);
    imem[3]  = li(4, 1023);
    imem[4]  = li(5, -1024);
    imem[5]  = rr(4'hE, 6, 5, 4);
    imem[6]  = rr(4'hE, 7, 4, 5);
    imem[7]  = ri(4'hA, 4, 4, 1);
    imem[8]  = jmp(-10);              // 8+1-10 -> 0xFFFFFFFF
    imem[63] = li(9, 'h55);
    release_reset();
    run(9);
    chk("d_pc_neg", PC, 32'hFFFFFFFF);
    chk("d_addi_wrap", dut.r_regs[2], 32'd0);
    chk("d_add_wrap", dut.r_regs[3], 32'hFFFFFFFE);
    chk("d_loadi_min", dut.r_regs[5], 32'hFFFFFC00);
    chk("d_slt_true", dut.r_regs[6], 32'd1);
    chk("d_slt_false", dut.r_regs[7], 32'd0);
    chk("d_addi_pos", dut.r_regs[4], 32'h400);
    run(1);
    chk("d_pc_wrap", PC, 32'd0);
    chk("d_r9", dut.r_regs[9], 32'h55);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
